// File: rtl/seg7_reader_if.sv
// Report channel of the segment reader: the decoded digit plus a valid/ready handshake.
interface seg7_reader_if;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_err;
    logic       out_dp;

    modport master (
        output out_valid,
        output out_code,
        output out_err,
        output out_dp,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_code,
        input  out_err,
        input  out_dp,
        output out_ready
    );
endinterface

// File: rtl/seg7_reader.sv
// Recovers the 3-bit digit code from an active-low 7-segment bus once the pattern is stable,
// reporting each new pattern once and counting illegal glyphs.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           seg_in,
    seg7_reader_if.master        out,
    output logic [7:0]           err_count
);

    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StSettle,
        StHold,
        StWaitChange
    } state_e;

    state_e     state_q;
    logic [7:0] seg_q;
    logic [7:0] cnt_q;
    logic [7:0] last_pat_q;
    logic       out_valid_q;
    logic [2:0] out_code_q;
    logic       out_err_q;
    logic       out_dp_q;
    logic [7:0] err_count_q;

    logic [2:0] glyph_code;
    logic       glyph_legal;
    logic       glyph_blank;

    // Lookup ignores the decimal point; blank is neither legal nor an error.
    always_comb begin
        glyph_code  = 3'd0;
        glyph_legal = 1'b1;
        glyph_blank = 1'b0;
        case (seg_q[6:0])
            7'h40:   glyph_code = 3'd0;
            7'h79:   glyph_code = 3'd1;
            7'h24:   glyph_code = 3'd2;
            7'h30:   glyph_code = 3'd3;
            7'h19:   glyph_code = 3'd4;
            7'h12:   glyph_code = 3'd5;
            7'h02:   glyph_code = 3'd6;
            7'h78:   glyph_code = 3'd7;
            7'h7F: begin
                glyph_legal = 1'b0;
                glyph_blank = 1'b1;
            end
            default: glyph_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StSettle;
            seg_q       <= 8'hFF;
            cnt_q       <= 8'd0;
            last_pat_q  <= 8'hFF;
            out_valid_q <= 1'b0;
            out_code_q  <= 3'd0;
            out_err_q   <= 1'b0;
            out_dp_q    <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            seg_q <= seg_in;
            if (seg_in != seg_q) begin
                cnt_q <= 8'd0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 8'd1;
            end

            case (state_q)
                StSettle: begin
                    if (cnt_q == CntMax) begin
                        last_pat_q <= seg_q;
                        if (glyph_blank) begin
                            state_q <= StWaitChange;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_code_q  <= glyph_legal ? glyph_code : 3'd0;
                            out_err_q   <= ~glyph_legal;
                            out_dp_q    <= ~seg_q[7];
                            state_q     <= StHold;
                            if (!glyph_legal && err_count_q != 8'hFF) begin
                                err_count_q <= err_count_q + 8'd1;
                            end
                        end
                    end
                end
                StHold: begin
                    if (out_valid_q && out.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StWaitChange;
                    end
                end
                StWaitChange: begin
                    if (seg_q != last_pat_q) begin
                        state_q <= StSettle;
                    end
                end
                default: state_q <= StSettle;
            endcase
        end
    end

    assign out.out_valid = out_valid_q;
    assign out.out_code  = out_code_q;
    assign out.out_err   = out_err_q;
    assign out.out_dp    = out_dp_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: expected reports are queued as stimulus is applied and
// matched against each accepted handshake.
module tb_seg7_reader;

    logic       clk;
    logic       reset;
    logic [7:0] seg_in;
    logic [7:0] err_count;

    seg7_reader_if rif ();

    seg7_reader #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .seg_in   (seg_in),
        .out      (rif),
        .err_count(err_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Entry layout: {code[2:0], err, dp}
    logic [4:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshakes are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset && rif.out_valid && rif.out_ready) begin
            check_eq("rpt_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check_eq("rpt_code", 32'(rif.out_code), 32'(e[4:2]));
                check_eq("rpt_err", 32'(rif.out_err), 32'(e[1]));
                check_eq("rpt_dp", 32'(rif.out_dp), 32'(e[0]));
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        check_eq("rst_valid", 32'(rif.out_valid), 32'd0);
        check_eq("rst_code", 32'(rif.out_code), 32'd0);
        check_eq("rst_err", 32'(rif.out_err), 32'd0);
        check_eq("rst_dp", 32'(rif.out_dp), 32'd0);
        check_eq("rst_errcnt", 32'(err_count), 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max_cycles) begin
            step(1);
            i++;
        end
        step(1);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int i;
        i = 0;
        while (!rif.out_valid && i < max_cycles) begin
            step(1);
            i++;
        end
        check_eq(tag, 32'(rif.out_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        seg_in        = 8'hFF;
        rif.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // 1: latency and single report of a held pattern
        seg_in        = 8'hA4;
        rif.out_ready = 1'b1;
        do_reset();
        exp_q.push_back({3'd2, 1'b0, 1'b0});
        for (int i = 1; i <= 6; i++) begin
            step(1);
            check_eq($sformatf("lat_valid_e%0d", i), 32'(rif.out_valid), 32'(i == 5));
        end
        step(50);
        check_eq("t1_drain", 32'(exp_q.size()), 32'd0);

        // 2: pattern changing before stability is not reported
        do_reset();
        seg_in = 8'h99;
        step(2);
        seg_in = 8'hB0;
        exp_q.push_back({3'd3, 1'b0, 1'b0});
        wait_drain("t2_drain", 20);
        step(20);

        // 3: illegal pattern and err_count saturation
        do_reset();
        seg_in = 8'h00;
        exp_q.push_back({3'd0, 1'b1, 1'b1});
        wait_drain("t3_drain", 20);
        check_eq("t3_errcnt1", 32'(err_count), 32'd1);
        for (int k = 0; k < 258; k++) begin
            seg_in = 8'hFF;
            step(8);
            seg_in = 8'h00;
            exp_q.push_back({3'd0, 1'b1, 1'b1});
            wait_drain("t3_loop_drain", 20);
            if (k == 253) check_eq("t3_errcnt_254", 32'(err_count), 32'd255);
        end
        check_eq("t3_errcnt_sat", 32'(err_count), 32'd255);

        // 4: report frozen while not accepted, queued change reported afterwards
        rif.out_ready = 1'b0;
        seg_in = 8'hF8;
        do_reset();
        exp_q.push_back({3'd7, 1'b0, 1'b0});
        exp_q.push_back({3'd0, 1'b0, 1'b0});
        step(10);
        seg_in = 8'hC0;
        step(19);
        check_eq("t4_hold_valid", 32'(rif.out_valid), 32'd1);
        check_eq("t4_hold_code", 32'(rif.out_code), 32'd7);
        step(1);
        rif.out_ready = 1'b1;
        wait_drain("t4_drain", 20);

        // 5: DP-only change re-reports; blanks never report
        do_reset();
        seg_in = 8'h12;
        exp_q.push_back({3'd5, 1'b0, 1'b1});
        wait_drain("t5_drain_a", 20);
        seg_in = 8'h92;
        exp_q.push_back({3'd5, 1'b0, 1'b0});
        wait_drain("t5_drain_b", 20);
        seg_in = 8'hFF;
        step(10);
        seg_in = 8'h7F;
        step(10);
        check_eq("t5_blank_valid", 32'(rif.out_valid), 32'd0);

        // 6: reset drops an in-flight report; held pattern reported again
        rif.out_ready = 1'b0;
        seg_in = 8'h00;
        step(1);
        wait_valid("t6_first_valid", 20);
        check_eq("t6_errcnt_pre", 32'(err_count), 32'd1);
        reset = 1'b1;
        step(1);
        check_eq("t6_rst_valid", 32'(rif.out_valid), 32'd0);
        check_eq("t6_rst_errcnt", 32'(err_count), 32'd0);
        reset = 1'b0;
        exp_q.push_back({3'd0, 1'b1, 1'b1});
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check_eq($sformatf("t6_lat_e%0d", i), 32'(rif.out_valid), 32'(i == 5));
        end
        rif.out_ready = 1'b1;
        wait_drain("t6_drain", 10);
        check_eq("t6_errcnt_post", 32'(err_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
